dht11_scheduler: RTL and testbench
==================================

Name: dht11_scheduler

Overview:
Measurement sequencer that sits directly upstream of the DHT11 core. It issues single-cycle start pulses at a programmable period and enforces the sensor's minimum inter-read gap. It watches the core's valid pulse with a timeout, retries failed reads, and latches the last good temperature/humidity pair for downstream display/UART logic.

Parameters:
P_SYS_CLK_HZ, 100_000_000, system clock frequency; LP_1_MS = P_SYS_CLK_HZ/1000 (must be >= 1)
P_PERIOD_MS, 2000, delay from end of a transaction to next scheduled trigger
P_MIN_GAP_MS, 1100, minimum delay between any two triggers (force and retry included)
P_TIMEOUT_MS, 30, max wait for core valid after a trigger
P_MAX_RETRY, 2, retries after a timeout before declaring failure (attempts = P_MAX_RETRY+1)

Ports:
iClk  in  1  system clock
iRstn  in  1  asynchronous active-low reset
iEnable  in  1  level; 1 = run periodic measurements
iForce  in  1  single-cycle request for an immediate measurement
oStart  out  1  single-cycle start pulse to DHT11 core
iValid  in  1  core result pulse; iTemp/iHumi stable while high
iTemp  in  16  core temperature {int,dec}
iHumi  in  16  core humidity {int,dec}
oTemp  out  16  last good temperature
oHumi  out  16  last good humidity
oUpdate  out  1  single-cycle pulse, same cycle oTemp/oHumi take new values
oFail  out  1  sticky failure flag
oErrCnt  out  8  saturating timeout counter
oBusy  out  1  high in TRIGGER and WAIT_RESP

Behaviour:
- Reset (async, iRstn=0): state IDLE; all outputs 0; timer, retry count, force-pending cleared. Reset mid-transaction abandons it silently.
- Single 32-bit cycle timer, cleared on every state entry. A timed state of M ms lasts exactly M*LP_1_MS cycles when uninterrupted.
- IDLE: iEnable=1 -> WAIT_PERIOD. The first trigger is a full period after enable (sensor power-up settling).
- WAIT_PERIOD: iEnable=0 -> IDLE, pending cleared. Timer reaching P_PERIOD_MS -> TRIGGER. iForce with elapsed >= P_MIN_GAP_MS -> TRIGGER next cycle. iForce earlier -> set pending; transition to TRIGGER on the cycle elapsed reaches P_MIN_GAP_MS.
- TRIGGER: lasts one cycle; oStart=1 in exactly this cycle (registered, asserted while state==TRIGGER). Pending cleared. -> WAIT_RESP. Ignores iEnable.
- WAIT_RESP:
  - iValid=1: oTemp<=iTemp, oHumi<=iHumi, oUpdate=1 next cycle; oFail<=0; retry<=0 -> WAIT_PERIOD (or IDLE if iEnable=0).
  - Timeout (P_TIMEOUT_MS elapsed, no valid): oErrCnt+1, saturating at 255.
    - If retry < P_MAX_RETRY: retry+1 -> RETRY_GAP.
    - Else: oFail<=1, retry<=0 -> WAIT_PERIOD (or IDLE if iEnable=0).
  - iValid and timeout in the same cycle: valid wins; no error counted.
  - iEnable=0 does not abort; the transaction completes first, because the core cannot be cancelled.
- RETRY_GAP: iEnable=0 -> IDLE. Timer reaching P_MIN_GAP_MS -> TRIGGER. iForce ignored.
- iValid outside WAIT_RESP is ignored: no latch, no oUpdate. iForce in IDLE, TRIGGER or WAIT_RESP is ignored and not queued.
- oFail stays set until the next successful read; oErrCnt clears only on reset.
- Unused state encodings -> IDLE.

Test Plan:
(Bench: P_SYS_CLK_HZ=1000 (1 cycle/ms), P_PERIOD_MS=20, P_MIN_GAP_MS=10, P_TIMEOUT_MS=5, P_MAX_RETRY=2.)
1. iEnable=1 at cycle 0 -> oStart pulses at cycle 21. iValid at 24 with iTemp=16'h1A05, iHumi=16'h3700 -> cycle 25: oTemp=16'h1A05, oHumi=16'h3700, oUpdate=1 for one cycle. Next oStart 21 cycles after the iValid cycle.
2. Never assert iValid -> 3 oStart pulses spaced 16 cycles apart (5 timeout + 10 gap + 1 trigger). After the third timeout: oFail=1, oErrCnt=3. Next scheduled read succeeds -> oFail=0, oErrCnt stays 3, oUpdate pulses.
3. iForce 3 cycles into WAIT_PERIOD -> oStart when elapsed reaches 10 (not 20). iForce 15 cycles into WAIT_PERIOD -> oStart on the next cycle.
4. iEnable dropped during WAIT_RESP, then iValid -> values latched, oUpdate pulses, state IDLE, no further oStart for 100 cycles.
5. iValid on the exact timeout cycle -> success path: oErrCnt unchanged, oUpdate=1. iValid pulsed while in WAIT_PERIOD -> no oUpdate, oTemp unchanged.
6. iRstn low during WAIT_RESP -> all outputs 0 immediately. A forced 300 consecutive timeouts -> oErrCnt saturates at 255.

Source files
------------

// File: rtl/dht11_scheduler.sv
// Measurement sequencer upstream of the DHT11 core: periodic/forced start pulses,
// minimum trigger spacing, response timeout with retries, and last-good-value latching.
module dht11_scheduler #(
  parameter int unsigned P_SYS_CLK_HZ = 100_000_000,
  parameter int unsigned P_PERIOD_MS  = 2000,
  parameter int unsigned P_MIN_GAP_MS = 1100,
  parameter int unsigned P_TIMEOUT_MS = 30,
  parameter int unsigned P_MAX_RETRY  = 2
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iEnable,
  input  logic        iForce,
  output logic        oStart,
  input  logic        iValid,
  input  logic [15:0] iTemp,
  input  logic [15:0] iHumi,
  output logic [15:0] oTemp,
  output logic [15:0] oHumi,
  output logic        oUpdate,
  output logic        oFail,
  output logic [7:0]  oErrCnt,
  output logic        oBusy
);

  localparam logic [31:0] LP_1_MS = 32'(P_SYS_CLK_HZ / 1000);

  // A timed state of M ms is left on its last cycle, i.e. when the timer reads M*LP_1_MS-1.
  localparam logic [31:0] PERIOD_LAST  = 32'(P_PERIOD_MS)  * LP_1_MS - 32'd1;
  localparam logic [31:0] GAP_LAST     = 32'(P_MIN_GAP_MS) * LP_1_MS - 32'd1;
  localparam logic [31:0] TIMEOUT_LAST = 32'(P_TIMEOUT_MS) * LP_1_MS - 32'd1;

  localparam int RW = (P_MAX_RETRY < 1) ? 1 : $clog2(P_MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_RETRY = RW'(P_MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_PERIOD = 3'd1,
    TRIGGER     = 3'd2,
    WAIT_RESP   = 3'd3,
    RETRY_GAP   = 3'd4
  } state_t;

  state_t        state;
  logic [31:0]   timer;
  logic [RW-1:0] retry;
  logic          pending;

  // NOTE: every register here uses non-blocking assignment; the pulse/timer defaults at the
  // top of the clocked branch are deliberately overridden by later assignments in the same cycle.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state   <= IDLE;
      timer   <= '0;
      retry   <= '0;
      pending <= 1'b0;
      oStart  <= 1'b0;
      oTemp   <= '0;
      oHumi   <= '0;
      oUpdate <= 1'b0;
      oFail   <= 1'b0;
      oErrCnt <= '0;
      oBusy   <= 1'b0;
    end else begin
      oStart  <= 1'b0;
      oUpdate <= 1'b0;
      timer   <= timer + 32'd1;

      case (state)
        IDLE: begin
          timer   <= '0;
          pending <= 1'b0;
          retry   <= '0;
          oBusy   <= 1'b0;
          if (iEnable) state <= WAIT_PERIOD;
        end

        WAIT_PERIOD: begin
          if (!iEnable) begin
            state   <= IDLE;
            pending <= 1'b0;
            timer   <= '0;
          end else if (timer >= PERIOD_LAST ||
                       ((iForce || pending) && timer >= GAP_LAST)) begin
            state  <= TRIGGER;
            oStart <= 1'b1;
            oBusy  <= 1'b1;
            timer  <= '0;
          end else if (iForce) begin
            // Too soon after the last trigger: remember it and fire once the gap is met.
            pending <= 1'b1;
          end
        end

        TRIGGER: begin
          state   <= WAIT_RESP;
          pending <= 1'b0;
          timer   <= '0;
        end

        WAIT_RESP: begin
          // The core cannot be cancelled, so iEnable only matters once the transaction ends.
          if (iValid) begin
            oTemp   <= iTemp;
            oHumi   <= iHumi;
            oUpdate <= 1'b1;
            oFail   <= 1'b0;
            retry   <= '0;
            oBusy   <= 1'b0;
            timer   <= '0;
            state   <= iEnable ? WAIT_PERIOD : IDLE;
          end else if (timer >= TIMEOUT_LAST) begin
            if (oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'd1;
            oBusy <= 1'b0;
            timer <= '0;
            if (retry < MAX_RETRY) begin
              retry <= retry + RW'(1);
              state <= RETRY_GAP;
            end else begin
              oFail <= 1'b1;
              retry <= '0;
              state <= iEnable ? WAIT_PERIOD : IDLE;
            end
          end
        end

        RETRY_GAP: begin
          if (!iEnable) begin
            state <= IDLE;
            retry <= '0;
            timer <= '0;
          end else if (timer >= GAP_LAST) begin
            state  <= TRIGGER;
            oStart <= 1'b1;
            oBusy  <= 1'b1;
            timer  <= '0;
          end
        end

        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed bench for dht11_scheduler at 1 cycle/ms; expected start pulses and updates are
// queued by the stimulus and matched by an independent negedge monitor.
module tb_dht11_scheduler;

  logic        iClk;
  logic        iRstn;
  logic        iEnable;
  logic        iForce;
  logic        oStart;
  logic        iValid;
  logic [15:0] iTemp;
  logic [15:0] iHumi;
  logic [15:0] oTemp;
  logic [15:0] oHumi;
  logic        oUpdate;
  logic        oFail;
  logic [7:0]  oErrCnt;
  logic        oBusy;

  dht11_scheduler #(
    .P_SYS_CLK_HZ(1000),
    .P_PERIOD_MS (20),
    .P_MIN_GAP_MS(10),
    .P_TIMEOUT_MS(5),
    .P_MAX_RETRY (2)
  ) dut (
    .iClk   (iClk),
    .iRstn  (iRstn),
    .iEnable(iEnable),
    .iForce (iForce),
    .oStart (oStart),
    .iValid (iValid),
    .iTemp  (iTemp),
    .iHumi  (iHumi),
    .oTemp  (oTemp),
    .oHumi  (oHumi),
    .oUpdate(oUpdate),
    .oFail  (oFail),
    .oErrCnt(oErrCnt),
    .oBusy  (oBusy)
  );

  typedef struct {
    logic [15:0] temp;
    logic [15:0] humi;
    int          cyc;
  } upd_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_start_en = 1'b1;
  int   start_q[$];
  upd_t upd_q[$];

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge iClk);
  endtask

  task automatic drive_valid(input logic [15:0] temp, input logic [15:0] humi);
    iValid = 1'b1;
    iTemp  = temp;
    iHumi  = humi;
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic pulse_force();
    iForce = 1'b1;
    @(negedge iClk);
    iForce = 1'b0;
  endtask

  task automatic push_upd(input logic [15:0] temp, input logic [15:0] humi, input int at);
    upd_t u;
    u.temp = temp;
    u.humi = humi;
    u.cyc  = at;
    upd_q.push_back(u);
  endtask

  // Monitor: every start pulse and every update must match the next queued expectation.
  always @(negedge iClk) begin
    if (iRstn) begin
      if (oStart && mon_start_en) begin
        if (start_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start: pulse at cycle %0d, none expected", cyc);
        end else begin
          check("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
        end
      end
      if (oUpdate) begin
        if (upd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_update: pulse at cycle %0d, temp 0x%0h, none expected",
                   cyc, oTemp);
        end else begin
          upd_t u;
          u = upd_q.pop_front();
          check("update_cycle", 32'(cyc), 32'(u.cyc));
          check("update_temp", 32'(oTemp), 32'(u.temp));
          check("update_humi", 32'(oHumi), 32'(u.humi));
        end
      end
    end
  end

  initial begin
    int t0;
    int e;
    int tt;

    iRstn   = 1'b0;
    iEnable = 1'b0;
    iForce  = 1'b0;
    iValid  = 1'b0;
    iTemp   = '0;
    iHumi   = '0;

    repeat (3) @(negedge iClk);
    check("rst_start", 32'(oStart), 32'd0);
    check("rst_temp", 32'(oTemp), 32'd0);
    check("rst_humi", 32'(oHumi), 32'd0);
    check("rst_update", 32'(oUpdate), 32'd0);
    check("rst_fail", 32'(oFail), 32'd0);
    check("rst_errcnt", 32'(oErrCnt), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    iRstn = 1'b1;
    @(negedge iClk);
    t0 = cyc;

    // First trigger a full period after enable, then a clean read.
    iEnable = 1'b1;
    start_q.push_back(t0 + 21);
    wait_to(t0 + 22);
    check("busy_wait_resp", 32'(oBusy), 32'd1);
    wait_to(t0 + 24);
    push_upd(16'h1A05, 16'h3700, t0 + 25);
    start_q.push_back(t0 + 45);
    drive_valid(16'h1A05, 16'h3700);
    check("busy_after_valid", 32'(oBusy), 32'd0);

    // No response: three attempts spaced 16 cycles, then failure and next periodic read.
    start_q.push_back(t0 + 61);
    start_q.push_back(t0 + 77);
    start_q.push_back(t0 + 103);
    wait_to(t0 + 51);
    check("errcnt_first_timeout", 32'(oErrCnt), 32'd1);
    check("fail_during_retry", 32'(oFail), 32'd0);
    wait_to(t0 + 83);
    check("fail_after_retries", 32'(oFail), 32'd1);
    check("errcnt_after_retries", 32'(oErrCnt), 32'd3);
    check("busy_after_fail", 32'(oBusy), 32'd0);
    wait_to(t0 + 106);
    push_upd(16'h1B00, 16'h3800, t0 + 107);
    drive_valid(16'h1B00, 16'h3800);
    check("fail_cleared", 32'(oFail), 32'd0);
    check("errcnt_kept", 32'(oErrCnt), 32'd3);

    // Early force waits for the minimum gap; late force fires on the next cycle.
    e = t0 + 107;
    start_q.push_back(e + 10);
    wait_to(e + 3);
    pulse_force();
    wait_to(e + 13);
    push_upd(16'h1C02, 16'h3905, e + 14);
    drive_valid(16'h1C02, 16'h3905);
    e = e + 14;
    start_q.push_back(e + 16);
    wait_to(e + 15);
    pulse_force();

    // Enable dropped mid-response: transaction completes, then the scheduler idles.
    wait_to(t0 + 139);
    iEnable = 1'b0;
    wait_to(t0 + 140);
    push_upd(16'h1D00, 16'h3A00, t0 + 141);
    drive_valid(16'h1D00, 16'h3A00);
    check("busy_after_disable", 32'(oBusy), 32'd0);
    wait_to(t0 + 241);
    check("idle_errcnt", 32'(oErrCnt), 32'd3);

    // Valid on the timeout cycle wins; stray valid in WAIT_PERIOD is ignored.
    tt = cyc;
    iEnable = 1'b1;
    start_q.push_back(tt + 21);
    wait_to(tt + 26);
    push_upd(16'h1E05, 16'h3B00, tt + 27);
    start_q.push_back(tt + 47);
    drive_valid(16'h1E05, 16'h3B00);
    check("errcnt_valid_on_timeout", 32'(oErrCnt), 32'd3);
    check("fail_valid_on_timeout", 32'(oFail), 32'd0);
    wait_to(tt + 32);
    drive_valid(16'hFFFF, 16'hFFFF);
    wait_to(tt + 35);
    check("stray_valid_temp", 32'(oTemp), 32'h1E05);
    check("stray_valid_humi", 32'(oHumi), 32'h3B00);

    // Asynchronous reset in WAIT_RESP clears every output at once.
    wait_to(tt + 49);
    check("busy_before_reset", 32'(oBusy), 32'd1);
    iRstn = 1'b0;
    #1;
    check("arst_start", 32'(oStart), 32'd0);
    check("arst_temp", 32'(oTemp), 32'd0);
    check("arst_humi", 32'(oHumi), 32'd0);
    check("arst_update", 32'(oUpdate), 32'd0);
    check("arst_fail", 32'(oFail), 32'd0);
    check("arst_errcnt", 32'(oErrCnt), 32'd0);
    check("arst_busy", 32'(oBusy), 32'd0);
    iEnable = 1'b0;
    repeat (2) @(negedge iClk);
    iRstn = 1'b1;

    // About 310 consecutive timeouts (58 cycles per 3): the error counter must saturate.
    mon_start_en = 1'b0;
    iEnable = 1'b1;
    repeat (6000) @(negedge iClk);
    check("errcnt_saturated", 32'(oErrCnt), 32'd255);
    check("fail_saturated", 32'(oFail), 32'd1);

    check("start_q_drained", 32'(start_q.size()), 32'd0);
    check("upd_q_drained", 32'(upd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
